mem_responder: RTL
==================

# mem_responder

Byte-wide memory responder sitting on the far side of the control unit's memory bus. Accepts one read or write request at a time from the initiator (control FSM fetch/store states), inserts a configurable number of wait states, then returns a one-cycle response carrying read data or a write acknowledge. Holds the program/data store as an internal byte array, so two-byte instruction fetches arrive as two back-to-back byte requests.

## Interface
- `DEPTH`, 256: bytes of storage; power of two; address index width `AW = $clog2(DEPTH)`.
- `WAIT_CYCLES`, 1: wait states between accept and response (0..15).
- `PROT_LIMIT`, 16'h0040: first writable address; used only with protection compiled in.
- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted when 0.
- `req_valid`  in  1  request present; initiator holds it and all `req_*` stable until `req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  8  write data.
- `req_ready`  out  1  request accepted on this edge when high with `req_valid`.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  8  read data; 8'h00 for writes and when `rsp_valid` low.
- `rsp_err`  out  1  valid with `rsp_valid`; 1 = write refused.

## Operation
- States: `S_MR_IDLE`, `S_MR_WAIT`, `S_MR_RESPOND`.
- IDLE: `req_ready`=1 (combinational from state, forced 0 while `reset`=0). On `req_valid`: latch write flag, `req_addr[AW-1:0]`, `req_wdata`; load wait counter with `WAIT_CYCLES`; go to WAIT, or RESPOND directly if `WAIT_CYCLES`=0.
- WAIT: `req_ready`=0; decrement counter; at 1 go to RESPOND. New requests ignored (initiator holds).
- RESPOND: `rsp_valid`=1 for exactly one cycle. Read: `rsp_rdata` = byte at latched address as of this cycle. Write: byte committed at the edge leaving RESPOND; `rsp_rdata`=0. Return to IDLE.
- Addressing: upper address bits ignored; address wraps modulo `DEPTH` (addr 16'h0105 with DEPTH 256 hits byte 5).
- No response backpressure; initiator always consumes `rsp_valid` in that cycle.
- Reset: state to IDLE, counter 0, latched request cleared, all outputs 0. Storage array not cleared. Reset mid-operation aborts; an uncommitted write is never performed.

## Timing
- Accept edge N; `rsp_valid` high during cycle N+1+`WAIT_CYCLES`; next accept no earlier than edge N+2+`WAIT_CYCLES`.
- Read-after-write to the same address returns the new byte, since writes commit before IDLE.
- `req_ready` and `rsp_valid` never high in the same cycle.

## Configuration
- `MEM_RESPONDER_PROTECT_EN` defined: writes with wrapped address < `PROT_LIMIT` are dropped, array unchanged, `rsp_err`=1 in RESPOND; reads unaffected; latency unchanged.
- Undefined: all writes commit; `rsp_err` tied 0; `PROT_LIMIT` unused.

## Structure
- Shared constants file `constants.v`: state codes `S_MR_IDLE/WAIT/RESPOND` (2-bit, distinct from control-state encodings), `MEM_READ`/`MEM_WRITE` opcode defines.
- Sub-module `mem_responder_ram`: single-port byte array, synchronous write, asynchronous read, parameter `DEPTH`; no reset.
- Top holds FSM, wait counter, request latch, protection check.

## Test plan
- Reset low for 3 cycles mid-write (WAIT state, addr 8'h10, data 8'hAA), release, read 8'h10 -> byte unchanged from prior value, all outputs 0 during reset.
- WAIT_CYCLES=1: write 8'h5A to 16'h0050, then read 16'h0050 -> `rsp_valid` exactly 2 cycles after each accept, `rsp_rdata`=8'h5A.
- WAIT_CYCLES=0: back-to-back reads of 16'h0050, 16'h0051 (instruction fetch pair) -> responses on consecutive-plus-one cycles, accepts every 2 cycles.
- Hold `req_valid` with new address during WAIT -> `req_ready`=0, request accepted only after RESPOND, first request's data returned first.
- Write 8'h33 to 16'h0123 (DEPTH 256), read 16'h0023 -> 8'h33 (wrap).
- With `MEM_RESPONDER_PROTECT_EN`: write 8'hFF to 16'h0010 -> `rsp_err`=1, later read returns old byte; write to 16'h0040 -> `rsp_err`=0, commits.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: FSM state codes, bus
// opcodes and the wait-counter width.
package mem_responder_pkg;

   // Codes kept clear of 2'b00 so they never alias the control-unit states.
   typedef enum logic [1:0] {
      S_MR_IDLE    = 2'b01,
      S_MR_WAIT    = 2'b10,
      S_MR_RESPOND = 2'b11
   } mr_state_t;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   // Wait counter covers WAIT_CYCLES in 0..15.
   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port byte store for mem_responder: synchronous write, asynchronous
// read, no reset (contents survive a responder reset).
module mem_responder_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Commit a byte on the rising edge when enabled.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: accepts one request at a time, inserts
// WAIT_CYCLES wait states, then returns a one-cycle response.
// Optional write protection below PROT_LIMIT: define MEM_RESPONDER_PROTECT_EN.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [15:0] PROT_LIMIT  = 16'h0040
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   mr_state_t        state;
   mr_state_t        state_nx;
   logic [CNT_W-1:0] wait_cnt;
   logic             lat_write;
   logic [AW-1:0]    lat_addr;
   logic [7:0]       lat_wdata;
   logic             prot_hit;
   logic             refuse;
   logic             ram_we;
   logic [7:0]       ram_rdata;

   // Wrapped address compared against the first writable byte.
   assign prot_hit = (32'(lat_addr) < 32'(PROT_LIMIT));

`ifdef MEM_RESPONDER_PROTECT_EN
   assign refuse = (lat_write == MEM_WRITE) && prot_hit;
`else
   // Protection compiled out: every write commits.
   assign refuse = prot_hit & 1'b0;
`endif

   // State register; reset aborts any in-flight request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_MR_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: accept in IDLE, count down in WAIT, single-cycle RESPOND.
   always_comb begin
      state_nx = state;
      case (state)
         S_MR_IDLE: begin
            if (req_valid) begin
               state_nx = (WAIT_CYCLES == 0) ? S_MR_RESPOND : S_MR_WAIT;
            end
         end
         S_MR_WAIT: begin
            if (wait_cnt <= CNT_W'(1)) begin
               state_nx = S_MR_RESPOND;
            end
         end
         S_MR_RESPOND: state_nx = S_MR_IDLE;
         default:      state_nx = S_MR_IDLE;
      endcase
   end

   // Outputs and write enable decoded from the current state.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      ram_we    = 1'b0;
      case (state)
         S_MR_IDLE: req_ready = reset;
         S_MR_RESPOND: begin
            rsp_valid = 1'b1;
            rsp_err   = refuse;
            if (lat_write == MEM_WRITE) begin
               ram_we = !refuse;
            end else begin
               rsp_rdata = ram_rdata;
            end
         end
         default: ;
      endcase
   end

   // Request latch and wait counter, loaded on accept.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wait_cnt  <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         if (state == S_MR_IDLE && req_valid) begin
            wait_cnt  <= CNT_W'(WAIT_CYCLES);
            lat_write <= req_write;
            lat_addr  <= req_addr[AW-1:0];
            lat_wdata <= req_wdata;
         end else if (state == S_MR_WAIT) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
      end
   end

   mem_responder_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .addr  (lat_addr),
      .wdata (lat_wdata),
      .rdata (ram_rdata)
   );

endmodule
